// File: rtl/pipelined_cpu16.sv
// 16-bit four-stage (IF, ID, EX/MEM, WB) in-order core with stack, one interrupt and RTI.
// Instruction memory has a back-door load port; a debug port reads any GPR.
module pipelined_cpu16 #(
    parameter int          IMEM_DEPTH = 64,
    parameter int          DMEM_DEPTH = 64,
    parameter logic [15:0] RESET_PC   = 16'd32,
    parameter logic [15:0] INT_VECTOR = 16'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  write_addr,
    output logic [15:0] result,
    input  logic        write_enable_fm,
    input  logic        rst_fm,
    input  logic [15:0] write_data_fm,
    input  logic [31:0] write_addr_fm,
    output logic [15:0] instruction,
    input  logic        interrupt
);

    localparam int STAGES = 2;
    localparam int IAW    = $clog2(IMEM_DEPTH);
    localparam int DAW    = $clog2(DMEM_DEPTH);
    localparam logic [DAW-1:0] SP_TOP = DAW'(DMEM_DEPTH - 1);

    localparam logic [4:0] OP_SETC = 5'b00001;
    localparam logic [4:0] OP_CLRC = 5'b00010;
    localparam logic [4:0] OP_NOT  = 5'b00100;
    localparam logic [4:0] OP_PUSH = 5'b01000;
    localparam logic [4:0] OP_POP  = 5'b01001;
    localparam logic [4:0] OP_LDD  = 5'b01010;
    localparam logic [4:0] OP_STD  = 5'b01100;
    localparam logic [4:0] OP_RTI  = 5'b10110;
    localparam logic [4:0] OP_MOV  = 5'b11000;
    localparam logic [4:0] OP_ADD  = 5'b11001;
    localparam logic [4:0] OP_SUB  = 5'b11010;
    localparam logic [4:0] OP_AND  = 5'b11011;
    localparam logic [4:0] OP_OR   = 5'b11100;

    typedef struct packed {
        logic [4:0]  op;
        logic [15:0] a;     // R[rs]
        logic [15:0] b;     // R[rd]
        logic        we;
        logic [2:0]  wa;
    } ex_req_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  wa;
        logic [15:0] data;
    } wb_req_t;

    function automatic logic [IAW-1:0] iidx(input logic [31:0] a);
        return IAW'(a % IMEM_DEPTH);
    endfunction

    function automatic logic [DAW-1:0] didx(input logic [15:0] a);
        return DAW'({16'b0, a} % DMEM_DEPTH);
    endfunction

    function automatic logic [DAW-1:0] sp_inc(input logic [DAW-1:0] s);
        return (s == SP_TOP) ? '0 : s + DAW'(1);
    endfunction

    function automatic logic [DAW-1:0] sp_dec(input logic [DAW-1:0] s);
        return (s == '0) ? SP_TOP : s - DAW'(1);
    endfunction

    logic [15:0]    imem [IMEM_DEPTH];
    logic [15:0]    dmem [DMEM_DEPTH];
    logic [15:0]    regs [8];

    logic [15:0]    pc;
    logic [DAW-1:0] sp, sp_nxt;
    logic           flag_c, flag_z, flag_n;
    logic           c_nxt, z_nxt, n_nxt;
    logic           irq_pending, in_isr, irq_enter;
    logic [STAGES:0] vld_pipe;   // [0] IF/ID, [1] ID/EX, [2] EX/WB
    logic [10:0]    if_id_ins;   // instruction bits [15:5]; [4:0] are don't-care
    ex_req_t        id_ex, id_dec;
    wb_req_t        ex_wb;
    logic [15:0]    fetch_ins;

    assign fetch_ins   = imem[iidx(32'(pc))];
    assign instruction = reset ? 16'h0000 : fetch_ins;
    assign result      = regs[write_addr];
    assign irq_enter   = irq_pending && (vld_pipe == '0);

    always_ff @(posedge clk) begin
        if (rst_fm) begin
            for (int i = 0; i < IMEM_DEPTH; i++) imem[i] <= '0;
        end else if (write_enable_fm) begin
            imem[iidx(write_addr_fm)] <= write_data_fm;
        end
    end

    // ---------------- ID: decode, bypassed register read, hazard detect
    logic [4:0]  id_op;
    logic [2:0]  id_rs, id_rd;
    logic [15:0] id_a, id_b;
    logic        use_rs, use_rd, stall;

    assign id_op = if_id_ins[10:6];
    assign id_rs = if_id_ins[5:3];
    assign id_rd = if_id_ins[2:0];
    assign id_a  = (ex_wb.we && ex_wb.wa == id_rs) ? ex_wb.data : regs[id_rs];
    assign id_b  = (ex_wb.we && ex_wb.wa == id_rd) ? ex_wb.data : regs[id_rd];

    always_comb begin
        id_dec    = '0;
        use_rs    = 1'b0;
        use_rd    = 1'b0;
        id_dec.op = id_op;
        id_dec.a  = id_a;
        id_dec.b  = id_b;
        case (id_op)
            OP_NOT:  begin use_rs = 1'b1; id_dec.we = 1'b1; id_dec.wa = id_rs; end
            OP_PUSH: use_rs = 1'b1;
            OP_POP:  begin id_dec.we = 1'b1; id_dec.wa = id_rs; end
            OP_LDD,
            OP_MOV:  begin use_rs = 1'b1; id_dec.we = 1'b1; id_dec.wa = id_rd; end
            OP_STD:  begin use_rs = 1'b1; use_rd = 1'b1; end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                use_rs = 1'b1; use_rd = 1'b1; id_dec.we = 1'b1; id_dec.wa = id_rd;
            end
            default: ;
        endcase
        if (!vld_pipe[0]) id_dec = '0;
    end

    // Only the EX-stage producer can be stale; the WB producer is covered by the bypass.
    assign stall = vld_pipe[0] && id_ex.we &&
                   ((use_rs && id_ex.wa == id_rs) || (use_rd && id_ex.wa == id_rd));

    // ---------------- EX/MEM
    logic           ex_mem_we, ex_rti, ex_zn;
    logic [DAW-1:0] ex_mem_addr;
    logic [15:0]    ex_mem_data, ex_res, rti_pc;
    logic [16:0]    sum17;

    always_comb begin
        ex_mem_we   = 1'b0;
        ex_mem_addr = '0;
        ex_mem_data = '0;
        ex_res      = '0;
        ex_rti      = 1'b0;
        ex_zn       = 1'b0;
        rti_pc      = '0;
        sum17       = '0;
        sp_nxt      = sp;
        c_nxt       = flag_c;
        z_nxt       = flag_z;
        n_nxt       = flag_n;
        if (vld_pipe[1]) begin
            case (id_ex.op)
                OP_SETC: c_nxt = 1'b1;
                OP_CLRC: c_nxt = 1'b0;
                OP_NOT:  begin ex_res = ~id_ex.a; ex_zn = 1'b1; end
                OP_PUSH: begin
                    ex_mem_we   = 1'b1;
                    ex_mem_addr = sp;
                    ex_mem_data = id_ex.a;
                    sp_nxt      = sp_dec(sp);
                end
                OP_POP: begin
                    sp_nxt = sp_inc(sp);
                    ex_res = dmem[sp_inc(sp)];
                end
                OP_LDD:  ex_res = dmem[didx(id_ex.a)];
                OP_STD: begin
                    ex_mem_we   = 1'b1;
                    ex_mem_addr = didx(id_ex.b);
                    ex_mem_data = id_ex.a;
                end
                OP_RTI: begin
                    ex_rti                = 1'b1;
                    {c_nxt, z_nxt, n_nxt} = dmem[sp_inc(sp)][2:0];
                    rti_pc                = dmem[sp_inc(sp_inc(sp))];
                    sp_nxt                = sp_inc(sp_inc(sp));
                end
                OP_MOV:  ex_res = id_ex.a;
                OP_ADD: begin
                    sum17  = {1'b0, id_ex.a} + {1'b0, id_ex.b};
                    ex_res = sum17[15:0];
                    c_nxt  = sum17[16];
                    ex_zn  = 1'b1;
                end
                OP_SUB: begin
                    ex_res = id_ex.b - id_ex.a;
                    c_nxt  = (id_ex.b >= id_ex.a);
                    ex_zn  = 1'b1;
                end
                OP_AND:  begin ex_res = id_ex.a & id_ex.b; ex_zn = 1'b1; end
                OP_OR:   begin ex_res = id_ex.a | id_ex.b; ex_zn = 1'b1; end
                default: ;
            endcase
            if (ex_zn) begin
                z_nxt = (ex_res == 16'h0000);
                n_nxt = ex_res[15];
            end
        end
    end

    // Interrupt entry only fires on an empty pipeline, so it never collides with an EX store.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
        end else if (irq_enter) begin
            dmem[sp]         <= pc;
            dmem[sp_dec(sp)] <= {13'b0, flag_c, flag_z, flag_n};
        end else if (ex_mem_we) begin
            dmem[ex_mem_addr] <= ex_mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'(i);
        end else if (ex_wb.we) begin
            regs[ex_wb.wa] <= ex_wb.data;
        end
    end

    // ---------------- pipeline control, PC, SP, flags, interrupt state
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            sp          <= SP_TOP;
            flag_c      <= 1'b0;
            flag_z      <= 1'b0;
            flag_n      <= 1'b0;
            irq_pending <= 1'b0;
            in_isr      <= 1'b0;
            vld_pipe    <= '0;
            if_id_ins   <= '0;
            id_ex       <= '0;
            ex_wb       <= '0;
        end else begin
            ex_wb.we    <= vld_pipe[1] && id_ex.we;
            ex_wb.wa    <= id_ex.wa;
            ex_wb.data  <= ex_res;
            vld_pipe[2] <= vld_pipe[1];
            sp          <= irq_enter ? sp_dec(sp_dec(sp)) : sp_nxt;
            flag_c      <= c_nxt;
            flag_z      <= z_nxt;
            flag_n      <= n_nxt;

            if (ex_rti) begin
                pc            <= rti_pc;
                if_id_ins     <= '0;
                id_ex         <= '0;
                vld_pipe[1:0] <= '0;
            end else if (irq_enter) begin
                pc            <= INT_VECTOR;
                if_id_ins     <= '0;
                id_ex         <= '0;
                vld_pipe[1:0] <= '0;
            end else if (stall) begin
                id_ex       <= '0;
                vld_pipe[1] <= 1'b0;
            end else begin
                id_ex       <= id_dec;
                vld_pipe[1] <= vld_pipe[0];
                if (irq_pending) begin
                    if_id_ins   <= '0;
                    vld_pipe[0] <= 1'b0;
                end else begin
                    if_id_ins   <= fetch_ins[15:5];
                    vld_pipe[0] <= 1'b1;
                    pc          <= pc + 16'd1;
                end
            end

            if (irq_enter)                  irq_pending <= 1'b0;
            else if (interrupt && !in_isr)  irq_pending <= 1'b1;

            if (irq_enter)   in_isr <= 1'b1;
            else if (ex_rti) in_isr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipelined_cpu16.sv
// Directed bench for pipelined_cpu16: debug-port vector table per phase plus
// hand-timed sequences for interrupt entry, RTI and reset while pending.
module tb_pipelined_cpu16;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  write_addr;
    logic [15:0] result;
    logic        write_enable_fm;
    logic        rst_fm;
    logic [15:0] write_data_fm;
    logic [31:0] write_addr_fm;
    logic [15:0] instruction;
    logic        interrupt;

    always #5 clk = ~clk;

    pipelined_cpu16 dut (
        .clk             (clk),
        .reset           (reset),
        .write_addr      (write_addr),
        .result          (result),
        .write_enable_fm (write_enable_fm),
        .rst_fm          (rst_fm),
        .write_data_fm   (write_data_fm),
        .write_addr_fm   (write_addr_fm),
        .instruction     (instruction),
        .interrupt       (interrupt)
    );

    typedef struct { int phase; logic [2:0] ra; logic [15:0] exp; } dbg_vec_t;
    typedef struct { int phase; logic [31:0] addr; logic [15:0] data; } prog_t;

    dbg_vec_t vecs[$];
    prog_t    progs[$];
    int       n_checks = 0;
    int       n_fail   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic vec(input int ph, input logic [2:0] ra, input logic [15:0] e);
        dbg_vec_t v;
        v.phase = ph; v.ra = ra; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic word(input int ph, input logic [31:0] a, input logic [15:0] d);
        prog_t p;
        p.phase = ph; p.addr = a; p.data = d;
        progs.push_back(p);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_prog(input int ph);
        rst_fm = 1'b1;
        cyc(1);
        rst_fm = 1'b0;
        foreach (progs[i]) begin
            if (progs[i].phase == ph) begin
                write_enable_fm = 1'b1;
                write_addr_fm   = progs[i].addr;
                write_data_fm   = progs[i].data;
                cyc(1);
            end
        end
        write_enable_fm = 1'b0;
    endtask

    task automatic run_debug(input int ph);
        foreach (vecs[i]) begin
            if (vecs[i].phase == ph) begin
                write_addr = vecs[i].ra;
                #1;
                check($sformatf("p%0d_R%0d", ph, vecs[i].ra), result, vecs[i].exp);
            end
        end
    endtask

    initial begin
        // debug-read expectations per phase
        for (int i = 0; i < 8; i++) vec(0, 3'(i), 16'(i));
        vec(1, 3'd1, 16'd1);   vec(1, 3'd2, 16'd1);
        vec(2, 3'd0, 16'hFFFF); vec(2, 3'd1, 16'd8); vec(2, 3'd2, 16'd10);
        vec(2, 3'd3, 16'd2);   vec(2, 3'd5, 16'd0);  vec(2, 3'd7, 16'd7);
        vec(3, 3'd1, 16'd2);   vec(3, 3'd2, 16'd2);  vec(3, 3'd4, 16'd1);
        vec(3, 3'd6, 16'd7);
        vec(4, 3'd1, 16'd1);   vec(4, 3'd2, 16'd2);

        // programs
        word(1, 32'd32, 16'h413F);  // PUSH R1
        word(1, 32'd33, 16'h4AFF);  // POP  R2
        word(2, 32'd32, 16'h0800);  // SETC
        word(2, 32'd33, 16'hCF3F);  // ADD R7,R1 -> R1=8
        word(2, 32'd34, 16'hC940);  // ADD R1,R2 -> R2=10 (RAW on R1)
        word(2, 32'd35, 16'h2000);  // NOT R0    -> FFFF
        word(2, 32'd36, 16'hC860);  // ADD R0,R3 -> 2, C=1 (RAW on R0)
        word(2, 32'd37, 16'hD5A0);  // SUB R5,R5 -> 0, C=1 Z=1
        word(3, 32'd0,  16'h615F);  // STD R1,R2
        word(3, 32'd1,  16'h529F);  // LDD R2,R4
        word(3, 32'd2,  16'hCC3F);  // ADD R4,R1
        word(3, 32'd3,  16'hB43F);  // RTI
        word(3, 32'd32, 16'h0800);  // SETC
        word(3, 32'd38, 16'hC7C0);  // MOV R7,R6 (first instruction after return)

        reset = 1'b1; write_addr = '0; write_enable_fm = 1'b0; rst_fm = 1'b0;
        write_data_fm = '0; write_addr_fm = '0; interrupt = 1'b0;
        cyc(2);

        // ---- phase 0: reset state and imem load port
        #1 check("instr_in_reset", instruction, 16'h0000);
        run_debug(0);
        write_enable_fm = 1'b1; write_addr_fm = 32'd32; write_data_fm = 16'hA123;
        cyc(1);
        rst_fm = 1'b1; write_data_fm = 16'h5555;   // clear must win over the write
        cyc(1);
        rst_fm = 1'b0; write_enable_fm = 1'b0;
        reset = 1'b0; #1;
        check("imem_cleared", instruction, 16'h0000);
        reset = 1'b1;
        write_enable_fm = 1'b1; write_addr_fm = 32'd96; write_data_fm = 16'hA123; // 96 mod 64 = 32
        cyc(1);
        write_enable_fm = 1'b0;
        reset = 1'b0; #1;
        check("first_fetch", instruction, 16'hA123);
        reset = 1'b1;
        cyc(1);

        // ---- phase 1: stack round trip
        load_prog(1);
        reset = 1'b0;
        cyc(12);
        run_debug(1);
        check("stk_mem63", dut.dmem[63], 16'd1);
        check("stk_sp", 16'(dut.sp), 16'd63);
        reset = 1'b1; cyc(1);

        // ---- phase 2: arithmetic with RAW hazards
        load_prog(2);
        reset = 1'b0;
        cyc(20);
        run_debug(2);
        check("ari_C", 16'(dut.flag_c), 16'd1);
        check("ari_Z", 16'(dut.flag_z), 16'd1);
        check("ari_N", 16'(dut.flag_n), 16'd0);
        reset = 1'b1; cyc(1);

        // ---- phase 3: interrupt entry, ISR, RTI
        load_prog(3);
        reset = 1'b0;
        cyc(5);
        interrupt = 1'b1;          // sampled on edge 6, PC then 38
        cyc(1);
        interrupt = 1'b0;
        check("irq_pending", 16'(dut.irq_pending), 16'd1);
        cyc(4);                    // three drain edges, entry on edge 10
        check("isr_pc", dut.pc, 16'd0);
        check("isr_sp", 16'(dut.sp), 16'd61);
        check("isr_saved_pc", dut.dmem[63], 16'd38);
        check("isr_saved_flags", dut.dmem[62], 16'd4);
        check("isr_in_isr", 16'(dut.in_isr), 16'd1);
        write_addr = 3'd6; #1;
        check("isr_R6_not_run", result, 16'd6);
        cyc(14);
        run_debug(3);
        check("rti_mem2", dut.dmem[2], 16'd1);
        check("rti_sp", 16'(dut.sp), 16'd63);
        check("rti_C", 16'(dut.flag_c), 16'd1);
        check("rti_Z", 16'(dut.flag_z), 16'd0);
        check("rti_N", 16'(dut.flag_n), 16'd0);
        check("rti_in_isr", 16'(dut.in_isr), 16'd0);
        reset = 1'b1; cyc(1);

        // ---- phase 4: reset while an interrupt is pending
        reset = 1'b0;
        cyc(2);
        interrupt = 1'b1;
        cyc(1);
        interrupt = 1'b0;
        check("rst_pending_set", 16'(dut.irq_pending), 16'd1);
        reset = 1'b1;
        cyc(1);
        check("rst_pc", dut.pc, 16'd32);
        check("rst_pending_clr", 16'(dut.irq_pending), 16'd0);
        check("rst_instr", instruction, 16'h0000);
        reset = 1'b0;
        cyc(8);
        check("rst_run_pc", dut.pc, 16'd40);
        check("rst_sp", 16'(dut.sp), 16'd63);
        check("rst_mem63", dut.dmem[63], 16'd0);
        check("rst_mem62", dut.dmem[62], 16'd0);
        check("rst_in_isr", 16'(dut.in_isr), 16'd0);
        run_debug(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
